// File: rtl/rob_queue.sv
// Circular reorder buffer: tagged allocation, multi-port writeback, operand lookup and
// in-order commit with redirect flush. Define ROB_BYPASS_EN to forward same-cycle writebacks to lookups.
module rob_queue #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int WB_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [1:0]                alloc_type,
    input  logic [4:0]                alloc_rd,
    input  logic [31:0]               alloc_pc,
    input  logic                      alloc_pred,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    input  logic [WB_PORTS*32-1:0]    wb_addr,
    input  logic [2*TAG_W-1:0]        q_tag,
    output logic [1:0]                q_ready,
    output logic [63:0]               q_value,
    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic [TAG_W-1:0]          commit_tag,
    output logic                      store_valid,
    input  logic                      store_ready,
    output logic [31:0]               store_addr,
    output logic [31:0]               store_data,
    output logic                      pred_upd_valid,
    output logic [31:0]               pred_upd_pc,
    output logic                      pred_upd_taken,
    output logic                      flush,
    output logic [31:0]               redirect_pc
);

    localparam int CNT_W = TAG_W + 1;

    typedef enum logic [1:0] {
        T_REG    = 2'b00,
        T_STORE  = 2'b01,
        T_BRANCH = 2'b10,
        T_JALR   = 2'b11
    } entry_type_t;

    logic [TAG_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    entry_type_t      e_type  [DEPTH];
    logic [4:0]       e_rd    [DEPTH];
    logic [31:0]      e_pc    [DEPTH];
    logic [31:0]      e_value [DEPTH];
    logic [31:0]      e_addr  [DEPTH];
    logic [DEPTH-1:0] e_pred;
    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_ready;

    logic [WB_PORTS-1:0] wb_hit;
    logic        alloc_fire, head_go, do_commit, store_start, store_fire;
    logic        retire, mispredict, do_flush;
    entry_type_t head_type;
    logic [31:0] head_value, head_addr, head_pc;

    assign alloc_ready = (count != CNT_W'(DEPTH)) && !flush;
    assign alloc_tag   = tail;
    assign alloc_fire  = rdy && alloc_valid && alloc_ready;

    assign head_type  = e_type[head];
    assign head_value = e_value[head];
    assign head_addr  = e_addr[head];
    assign head_pc    = e_pc[head];

    // A store occupies the head until its handshake; nothing behind it may retire meanwhile.
    assign head_go     = (count != '0) && e_ready[head];
    assign do_commit   = rdy && head_go && !store_valid && (head_type != T_STORE);
    assign store_start = rdy && head_go && !store_valid && (head_type == T_STORE);
    assign store_fire  = rdy && store_valid && store_ready;
    assign retire      = do_commit || store_fire;
    assign mispredict  = head_value[0] != e_pred[head];
    assign do_flush    = do_commit &&
                         ((head_type == T_JALR) || ((head_type == T_BRANCH) && mispredict));

    // Writebacks to free slots, or during the redirect cycle, are dropped.
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++)
            wb_hit[p] = wb_valid[p] && e_valid[wb_tag[p*TAG_W +: TAG_W]] && !flush;
    end

    always_comb begin
        // NOTE: default every output before the loop so no path leaves it unassigned (no latch).
        q_ready = '0;
        q_value = '0;
        for (int i = 0; i < 2; i++) begin
            q_ready[i]         = e_ready[q_tag[i*TAG_W +: TAG_W]];
            q_value[i*32 +: 32] = e_value[q_tag[i*TAG_W +: TAG_W]];
`ifdef ROB_BYPASS_EN
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rdy && wb_hit[p] && (wb_tag[p*TAG_W +: TAG_W] == q_tag[i*TAG_W +: TAG_W])) begin
                    q_ready[i]          = 1'b1;
                    q_value[i*32 +: 32] = wb_value[p*32 +: 32];
                end
            end
`endif
        end
    end

    // NOTE: payload storage has no reset; e_valid/e_ready gate every use, so contents never leak.
    always_ff @(posedge clk) begin
        if (rdy && !do_flush) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_hit[p]) begin
                    e_value[wb_tag[p*TAG_W +: TAG_W]] <= wb_value[p*32 +: 32];
                    e_addr[wb_tag[p*TAG_W +: TAG_W]]  <= wb_addr[p*32 +: 32];
                end
            end
            if (alloc_fire) begin
                e_type[tail] <= entry_type_t'(alloc_type);
                e_rd[tail]   <= alloc_rd;
                e_pc[tail]   <= alloc_pc;
                e_pred[tail] <= alloc_pred;
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            e_valid        <= '0;
            e_ready        <= '0;
            commit_valid   <= 1'b0;
            commit_rd      <= '0;
            commit_value   <= '0;
            commit_tag     <= '0;
            store_valid    <= 1'b0;
            store_addr     <= '0;
            store_data     <= '0;
            pred_upd_valid <= 1'b0;
            pred_upd_pc    <= '0;
            pred_upd_taken <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
        end else if (rdy) begin
            commit_valid   <= 1'b0;
            pred_upd_valid <= 1'b0;
            flush          <= 1'b0;

            if (do_flush) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                e_valid <= '0;
                e_ready <= '0;
            end else begin
                for (int p = 0; p < WB_PORTS; p++)
                    if (wb_hit[p]) e_ready[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                if (retire) begin
                    e_valid[head] <= 1'b0;
                    e_ready[head] <= 1'b0;
                    head          <= head + TAG_W'(1);
                end
                if (alloc_fire) begin
                    e_valid[tail] <= 1'b1;
                    e_ready[tail] <= 1'b0;
                    tail          <= tail + TAG_W'(1);
                end
                if (alloc_fire && !retire)      count <= count + 1'b1;
                else if (!alloc_fire && retire) count <= count - 1'b1;
            end

            if (do_commit) begin
                case (head_type)
                    T_REG: begin
                        commit_valid <= 1'b1;
                        commit_rd    <= e_rd[head];
                        commit_value <= head_value;
                        commit_tag   <= head;
                    end
                    T_JALR: begin
                        commit_valid <= 1'b1;
                        commit_rd    <= e_rd[head];
                        commit_value <= head_value;
                        commit_tag   <= head;
                        flush        <= 1'b1;
                        redirect_pc  <= head_addr;
                    end
                    T_BRANCH: begin
                        pred_upd_valid <= 1'b1;
                        pred_upd_pc    <= head_pc;
                        pred_upd_taken <= head_value[0];
                        if (mispredict) begin
                            flush       <= 1'b1;
                            redirect_pc <= head_value[0] ? head_addr : head_pc + 32'd4;
                        end
                    end
                    default: ;
                endcase
            end

            if (store_start) begin
                store_valid <= 1'b1;
                store_addr  <= head_addr;
                store_data  <= head_value;
            end else if (store_fire) begin
                store_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Directed self-checking bench for rob_queue at DEPTH=4: fill/wrap, ordering, branches,
// jalr, store stall, rdy freeze and lookup visibility (with or without ROB_BYPASS_EN).
module tb_rob_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int WBP   = 2;

    logic              clk = 1'b0;
    logic              rst, rdy;
    logic              alloc_valid, alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic [1:0]        alloc_type;
    logic [4:0]        alloc_rd;
    logic [31:0]       alloc_pc;
    logic              alloc_pred;
    logic [WBP-1:0]    wb_valid;
    logic [WBP*TAG_W-1:0] wb_tag;
    logic [WBP*32-1:0] wb_value, wb_addr;
    logic [2*TAG_W-1:0] q_tag;
    logic [1:0]        q_ready;
    logic [63:0]       q_value;
    logic              commit_valid;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_value;
    logic [TAG_W-1:0]  commit_tag;
    logic              store_valid, store_ready;
    logic [31:0]       store_addr, store_data;
    logic              pred_upd_valid, pred_upd_taken, flush;
    logic [31:0]       pred_upd_pc, redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WB_PORTS(WBP)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_type(alloc_type), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr),
        .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag),
        .store_valid(store_valid), .store_ready(store_ready),
        .store_addr(store_addr), .store_data(store_data),
        .pred_upd_valid(pred_upd_valid), .pred_upd_pc(pred_upd_pc), .pred_upd_taken(pred_upd_taken),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_type = 2'b00; alloc_rd = '0;
        alloc_pc = '0; alloc_pred = 1'b0; wb_valid = '0; wb_tag = '0; wb_value = '0;
        wb_addr = '0; q_tag = '0; store_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                            input logic pred);
        alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred = pred;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [TAG_W-1:0] tag, input logic [31:0] v,
                          input logic [31:0] a);
        wb_valid[p] = 1'b1;
        wb_tag[p*TAG_W +: TAG_W] = tag;
        wb_value[p*32 +: 32] = v;
        wb_addr[p*32 +: 32] = a;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ready got %0h want 1", alloc_ready); end
        n_checks++; if (alloc_tag !== 2'd0) begin n_fail++; $display("FAIL rst_alloc_tag got %0h want 0", alloc_tag); end
        n_checks++; if ({commit_valid, store_valid, pred_upd_valid, flush} !== 4'b0) begin
            n_fail++; $display("FAIL rst_pulses got %b want 0000", {commit_valid, store_valid, pred_upd_valid, flush}); end
        n_checks++; if ({redirect_pc, commit_value, store_addr, pred_upd_pc} !== 128'd0) begin
            n_fail++; $display("FAIL rst_data got nonzero %h", {redirect_pc, commit_value, store_addr, pred_upd_pc}); end
        n_checks++; if (q_ready !== 2'b00) begin n_fail++; $display("FAIL rst_q_ready got %b want 00", q_ready); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_alloc(2'b00, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_alloc_ready got %0h want 0", alloc_ready); end
        n_checks++; if (alloc_tag !== 2'd0) begin n_fail++; $display("FAIL full_alloc_tag got %0h want 0", alloc_tag); end
        set_wb(0, 2'd0, 32'hA0, 32'h0);
        step();
        wb_valid = '0;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL wb_edge_commit got %0h want 0", commit_valid); end
        step();
        n_checks++; if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 2'd0, 5'd1, 32'hA0}) begin
            n_fail++; $display("FAIL fill_commit got v%0h t%0h rd%0h val%h want v1 t0 rd1 val000000a0",
                               commit_valid, commit_tag, commit_rd, commit_value); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL after_commit_ready got %0h want 1", alloc_ready); end
        do_alloc(2'b00, 5'd9, 32'h2000, 1'b0);
        n_checks++; if (alloc_tag !== 2'd1) begin n_fail++; $display("FAIL wrap_alloc_tag got %0h want 1", alloc_tag); end
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_full got %0h want 0", alloc_ready); end
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL commit_pulse_len got %0h want 0", commit_valid); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(2'b00, 5'(i + 5), 32'h300 + 32'(4 * i), 1'b0);
        set_wb(0, 2'd2, 32'h22, 32'h0);
        step();
        wb_valid = '0;
        q_tag = {2'd0, 2'd2};
        #1;
        n_checks++; if ({q_ready[0], q_value[31:0]} !== {1'b1, 32'h22}) begin
            n_fail++; $display("FAIL lookup_tag2 got r%0h v%h want r1 v00000022", q_ready[0], q_value[31:0]); end
        // Same tag on both ports: port 1 must win.
        set_wb(0, 2'd1, 32'h99, 32'h0);
        set_wb(1, 2'd1, 32'h11, 32'h0);
        step();
        wb_valid = '0;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL oo_no_early_commit got %0h want 0", commit_valid); end
        set_wb(0, 2'd0, 32'h00, 32'h0);
        step();
        wb_valid = '0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_v;
            exp_v = (i == 0) ? 32'h00 : (i == 1) ? 32'h11 : 32'h22;
            step();
            n_checks++; if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 2'(i), 5'(i + 5), exp_v}) begin
                n_fail++; $display("FAIL oo_commit%0d got v%0h t%0h rd%0h val%h want v1 t%0h rd%0h val%h",
                                   i, commit_valid, commit_tag, commit_rd, commit_value, i, i + 5, exp_v); end
        end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL oo_drain got %0h want 0", commit_valid); end
    endtask

    task automatic test_branch_mispredict();
        do_reset();
        do_alloc(2'b10, 5'd0, 32'h80, 1'b0);
        do_alloc(2'b00, 5'd3, 32'h84, 1'b0);
        set_wb(0, 2'd0, 32'h1, 32'h100);
        set_wb(1, 2'd1, 32'h55, 32'h0);
        step();
        wb_valid = '0;
        step();
        n_checks++; if ({pred_upd_valid, pred_upd_taken, pred_upd_pc} !== {1'b1, 1'b1, 32'h80}) begin
            n_fail++; $display("FAIL mp_pred_upd got v%0h tk%0h pc%h want v1 tk1 pc00000080",
                               pred_upd_valid, pred_upd_taken, pred_upd_pc); end
        n_checks++; if ({flush, redirect_pc} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL mp_flush got f%0h pc%h want f1 pc00000100", flush, redirect_pc); end
        n_checks++; if ({alloc_ready, alloc_tag, commit_valid} !== {1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL mp_flush_cycle got rdy%0h tag%0h cv%0h want rdy0 tag0 cv0",
                               alloc_ready, alloc_tag, commit_valid); end
        q_tag = {2'd0, 2'd1};
        step();
        n_checks++; if ({flush, commit_valid, alloc_ready, alloc_tag, q_ready[0]} !== {1'b0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL mp_after got f%0h cv%0h rdy%0h tag%0h qr%0h want f0 cv0 rdy1 tag0 qr0",
                               flush, commit_valid, alloc_ready, alloc_tag, q_ready[0]); end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL mp_younger_commit got %0h want 0", commit_valid); end
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        do_alloc(2'b10, 5'd0, 32'h50, 1'b0);
        do_alloc(2'b10, 5'd0, 32'h40, 1'b1);
        set_wb(0, 2'd0, 32'h0, 32'h500);
        set_wb(1, 2'd1, 32'h0, 32'h200);
        step();
        wb_valid = '0;
        step();
        n_checks++; if ({pred_upd_valid, pred_upd_taken, pred_upd_pc, flush} !== {1'b1, 1'b0, 32'h50, 1'b0}) begin
            n_fail++; $display("FAIL br_correct got v%0h tk%0h pc%h f%0h want v1 tk0 pc00000050 f0",
                               pred_upd_valid, pred_upd_taken, pred_upd_pc, flush); end
        step();
        n_checks++; if ({pred_upd_valid, pred_upd_pc, flush, redirect_pc} !== {1'b1, 32'h40, 1'b1, 32'h44}) begin
            n_fail++; $display("FAIL br_nt_redirect got v%0h pc%h f%0h rpc%h want v1 pc00000040 f1 rpc00000044",
                               pred_upd_valid, pred_upd_pc, flush, redirect_pc); end
    endtask

    task automatic test_jalr();
        do_reset();
        do_alloc(2'b11, 5'd9, 32'h10, 1'b0);
        set_wb(1, 2'd0, 32'h14, 32'h300);
        step();
        wb_valid = '0;
        step();
        n_checks++; if ({commit_valid, commit_rd, commit_value, flush, redirect_pc} !== {1'b1, 5'd9, 32'h14, 1'b1, 32'h300}) begin
            n_fail++; $display("FAIL jalr got cv%0h rd%0h val%h f%0h rpc%h want cv1 rd9 val00000014 f1 rpc00000300",
                               commit_valid, commit_rd, commit_value, flush, redirect_pc); end
    endtask

    task automatic test_store_stall();
        do_reset();
        do_alloc(2'b01, 5'd0, 32'h60, 1'b0);
        do_alloc(2'b00, 5'd4, 32'h64, 1'b0);
        set_wb(0, 2'd0, 32'hD0D0, 32'h1000);
        set_wb(1, 2'd1, 32'h77, 32'h0);
        step();
        wb_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({store_valid, store_addr, store_data, commit_valid} !== {1'b1, 32'h1000, 32'hD0D0, 1'b0}) begin
                n_fail++; $display("FAIL st_hold%0d got v%0h a%h d%h cv%0h want v1 a00001000 d0000d0d0 cv0",
                                   i, store_valid, store_addr, store_data, commit_valid); end
        end
        store_ready = 1'b1;
        step();
        store_ready = 1'b0;
        n_checks++; if ({store_valid, commit_valid} !== 2'b00) begin
            n_fail++; $display("FAIL st_handshake got v%0h cv%0h want v0 cv0", store_valid, commit_valid); end
        step();
        n_checks++; if ({commit_valid, commit_tag, commit_value} !== {1'b1, 2'd1, 32'h77}) begin
            n_fail++; $display("FAIL st_next_commit got cv%0h t%0h val%h want cv1 t1 val00000077",
                               commit_valid, commit_tag, commit_value); end
        do_alloc(2'b01, 5'd0, 32'h68, 1'b0);
        set_wb(0, 2'd2, 32'h5, 32'h2000);
        step();
        wb_valid = '0;
        step();
        n_checks++; if (store_valid !== 1'b1) begin n_fail++; $display("FAIL st2_valid got %0h want 1", store_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if ({store_valid, alloc_tag} !== {1'b0, 2'd0}) begin
            n_fail++; $display("FAIL st_rst_drop got v%0h tag%0h want v0 tag0", store_valid, alloc_tag); end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        do_alloc(2'b00, 5'd2, 32'h70, 1'b0);
        set_wb(0, 2'd0, 32'h42, 32'h0);
        step();
        wb_valid = '0;
        rdy = 1'b0;
        alloc_valid = 1'b1;
        step();
        step();
        alloc_valid = 1'b0;
        n_checks++; if ({commit_valid, alloc_tag} !== {1'b0, 2'd1}) begin
            n_fail++; $display("FAIL rdy_freeze got cv%0h tag%0h want cv0 tag1", commit_valid, alloc_tag); end
        rdy = 1'b1;
        step();
        n_checks++; if ({commit_valid, commit_value} !== {1'b1, 32'h42}) begin
            n_fail++; $display("FAIL rdy_resume got cv%0h val%h want cv1 val00000042", commit_valid, commit_value); end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_pulse_once got %0h want 0", commit_valid); end
    endtask

    task automatic test_bypass();
        logic exp_same;
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(2'b00, 5'(i + 1), 32'h0, 1'b0);
        set_wb(0, 2'd3, 32'h99, 32'h0);
        step();
        wb_valid = '0;
        q_tag = {2'd0, 2'd3};
        #1;
        n_checks++; if (q_ready[0] !== 1'b0) begin n_fail++; $display("FAIL wb_free_ignored got %0h want 0", q_ready[0]); end
        do_alloc(2'b00, 5'd4, 32'h0, 1'b0);
        set_wb(1, 2'd3, 32'hDEAD, 32'h0);
        #1;
`ifdef ROB_BYPASS_EN
        exp_same = 1'b1;
        n_checks++; if (q_value[31:0] !== 32'hDEAD) begin
            n_fail++; $display("FAIL bypass_value got %h want 0000dead", q_value[31:0]); end
`else
        exp_same = 1'b0;
`endif
        n_checks++; if (q_ready[0] !== exp_same) begin
            n_fail++; $display("FAIL lookup_same_cycle got %0h want %0h", q_ready[0], exp_same); end
        step();
        wb_valid = '0;
        #1;
        n_checks++; if ({q_ready[0], q_value[31:0]} !== {1'b1, 32'hDEAD}) begin
            n_fail++; $display("FAIL lookup_next_cycle got r%0h v%h want r1 v0000dead", q_ready[0], q_value[31:0]); end
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_out_of_order();
        test_branch_mispredict();
        test_branch_not_taken();
        test_jalr();
        test_store_stall();
        test_rdy_hold();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_queue.md
# rob_queue

Parametrised reorder buffer: the next generation of the out-of-order core's in-order retirement block. It allocates tagged entries at dispatch and accepts results from WB_PORTS writeback channels. It serves two operand lookups for the decoder and retires one entry per cycle to the register file, the load/store buffer or the branch predictor. Branch and JALR redirects are resolved at commit, where they flush the whole window.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥4.
- TAG_W, $clog2(DEPTH), entry tag width.
- WB_PORTS, 2, number of independent writeback channels.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds and outputs hold.
- alloc_valid  in  1  dispatch request.
- alloc_ready  out  1  equals (count != DEPTH) && !flush.
- alloc_tag  out  TAG_W  tag given to the next allocation; equals tail.
- alloc_type  in  2  entry type: 00 reg-writing, 01 store, 10 branch, 11 jalr.
- alloc_rd  in  5  destination register.
- alloc_pc  in  32  instruction PC.
- alloc_pred  in  1  predicted-taken bit.
- wb_valid  in  WB_PORTS  per-port result strobe.
- wb_tag  in  WB_PORTS*TAG_W  tag of each result.
- wb_value  in  WB_PORTS*32  rd value, store data, or taken bit (branch, bit 0).
- wb_addr  in  WB_PORTS*32  store address or jump target.
- q_tag  in  2*TAG_W  operand lookup tags.
- q_ready  out  2  entry is ready.
- q_value  out  64  entry values.
- commit_valid  out  1  pulse: register write.
- commit_rd  out  5  destination register.
- commit_value  out  32  value to write.
- commit_tag  out  TAG_W  retiring tag, for rename-table clear.
- store_valid  out  1  store request to the LSB.
- store_ready  in  1  LSB accepts the store.
- store_addr  out  32  store address.
- store_data  out  32  store data.
- pred_upd_valid  out  1  pulse: branch outcome.
- pred_upd_pc  out  32  PC of the branch.
- pred_upd_taken  out  1  actual outcome.
- flush  out  1  one-cycle pulse: redirect.
- redirect_pc  out  32  fetch restart address.

## Operation
- The queue is circular, with head, tail and a count of TAG_W+1 bits. All DEPTH slots are usable; full is count==DEPTH and empty is count==0.
- **Allocation.** When alloc_valid && alloc_ready, the entry at tail is written with its type, rd, pc and pred, and its ready bit is cleared. tail then increments modulo DEPTH.
- **Writeback.** For each port with wb_valid, the entry wb_tag gets value and addr written and ready set.
  - If two ports carry the same tag, the higher-numbered port wins.
  - A writeback to a free entry is ignored.
- **Lookups** are combinational reads of ready and value for each q_tag.
- **Commit** examines the head entry only, and only when count>0 and the head entry is ready:
  - **reg-writing:** commit_valid pulses with rd, value and tag.
  - **jalr:** commit_valid pulses; flush pulses with redirect_pc = addr.
  - **branch:** pred_upd_valid pulses.
    - If taken ≠ pred: flush pulses with redirect_pc = taken ? addr : pc+4.
    - Otherwise no flush.
  - **store:** store_valid rises with addr and data and is held until store_ready. The entry retires on the edge where store_valid && store_ready. store_valid then drops for at least one cycle.
- **Flush.** On the edge that registers flush=1, head, tail and count are reset to 0 and all ready bits are cleared.
  - Allocation and writeback presented on that edge are discarded.
  - While flush=1, alloc_ready=0 and wb_valid is ignored.
- Simultaneous alloc and commit in the same cycle changes count by net 0. alloc_ready does not anticipate a same-cycle retirement.

## Timing
- Reset values:
  - head, tail and count are 0; all ready bits are 0.
  - All pulse outputs and store_valid are 0.
  - commit_rd, commit_value, commit_tag, store_addr, store_data, pred_upd_pc, pred_upd_taken and redirect_pc are 0.
- alloc_ready is 1 in the cycle after reset.
- Commit outputs are registered and appear in the cycle after the head becomes ready. The earliest commit comes 2 cycles after allocation (alloc edge, then wb edge, then commit edge).
- Pulses last exactly one cycle. The next commit can occur in the cycle immediately following.
- rst overrides everything, including a flush or a store in progress. Asserting rst while store_valid=1 drops store_valid without a handshake.
- rdy=0 freezes state and holds all outputs. A pending pulse is not repeated.

## Configuration
- ROB_BYPASS_EN defined: q_ready and q_value also forward same-cycle wb_valid matches. Port priority is the highest port; the forward occurs only if the tag is allocated.
- ROB_BYPASS_EN undefined: lookups see stored state only, so a result is visible one cycle after its writeback.

## Test plan
- Fill and wrap: DEPTH=4; allocate 4 → alloc_ready=0 with count=4. Write back tag0 → next cycle commit_valid with commit_tag=0. Allocate again → alloc_tag=0 (wrap).
- Out-of-order writeback: write back tag2 then tag1 then tag0 → commits occur in order 0, 1, 2 on consecutive cycles.
- Branch mispredict: pred=0, wb_value=1, addr=0x100 → pred_upd_taken=1, flush=1, redirect_pc=0x100. The next cycle alloc_tag=0 and count=0; a younger ready entry never commits.
- Branch not taken, predicted taken: pc=0x40 → redirect_pc=0x44. A correct prediction produces no flush.
- Store stall: store head ready with store_ready=0 for 3 cycles → store_valid held with addr and data stable. Retires on the handshake edge.
- Bypass (macro on): q_tag=3 while wb writes tag3 with 0xDEAD → q_ready=1 and q_value=0xDEAD in the same cycle. With the macro off, this is visible one cycle later.
